// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: drives bubble/flush of IF/ID, ID/EX, EX/MEM, MEM/WB segment registers.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int MISS_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       reg_read_en_ID,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             load_EX,
    input  logic             br_EX,
    input  logic             jalr_EX,
    input  logic             jal_ID,
    input  logic             miss_MEM,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             stalled,
    output logic [CNT_W-1:0] miss_cycles,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_loaduse,
    output logic [CNT_W-1:0] perf_ctrl_flush,
`endif
    output logic             miss_timeout
);

    typedef enum logic {RUN = 1'b0, MISS = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MISS_TIMEOUT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] miss_cycles_nxt;
    logic             load_use;
    logic             stall_evt, loaduse_evt, ctrl_evt;

    assign load_use = load_EX && (rd_EX != 5'd0) &&
                      ((reg_read_en_ID[0] && (rs1_ID == rd_EX)) ||
                       (reg_read_en_ID[1] && (rs2_ID == rd_EX)));

    assign stalled = (state == MISS);

    always_comb begin
        state_nxt       = state;
        miss_cycles_nxt = miss_cycles;
        bubbleF = 1'b0; bubbleD = 1'b0; bubbleE = 1'b0; bubbleM = 1'b0; bubbleW = 1'b0;
        flushF  = 1'b0; flushD  = 1'b0; flushE  = 1'b0; flushM  = 1'b0; flushW  = 1'b0;
        stall_evt   = 1'b0;
        loaduse_evt = 1'b0;
        ctrl_evt    = 1'b0;

        case (state)
            RUN: begin
                if (miss_MEM) begin
                    state_nxt       = MISS;
                    miss_cycles_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            MISS: begin
                if (miss_MEM) begin
                    if (miss_cycles != CNT_MAX) miss_cycles_nxt = miss_cycles + 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        // A live miss masks branch and load-use; they are seen again once the held instructions resume.
        if (!rst) begin
            flushF = 1'b1; flushD = 1'b1; flushE = 1'b1; flushM = 1'b1; flushW = 1'b1;
        end else if (miss_MEM) begin
            bubbleF = 1'b1; bubbleD = 1'b1; bubbleE = 1'b1; bubbleM = 1'b1;
            flushW    = 1'b1;
            stall_evt = 1'b1;
        end else if (br_EX || jalr_EX) begin
            flushD   = 1'b1;
            flushE   = 1'b1;
            ctrl_evt = 1'b1;
        end else if (jal_ID) begin
            flushD   = 1'b1;
            ctrl_evt = 1'b1;
        end else if (load_use) begin
            bubbleF     = 1'b1;
            bubbleD     = 1'b1;
            flushE      = 1'b1;
            loaduse_evt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= RUN;
            miss_cycles  <= '0;
            miss_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            miss_cycles <= miss_cycles_nxt;
            if (miss_MEM && (miss_cycles_nxt >= TIMEOUT_C)) miss_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_loaduse      <= '0;
            perf_ctrl_flush   <= '0;
        end else begin
            if (stall_evt && (perf_stall_cycles != CNT_MAX))
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (loaduse_evt && (perf_loaduse != CNT_MAX))
                perf_loaduse <= perf_loaduse + 1'b1;
            if (ctrl_evt && (perf_ctrl_flush != CNT_MAX))
                perf_ctrl_flush <= perf_ctrl_flush + 1'b1;
        end
    end
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ loaduse_evt ^ ctrl_evt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver pushes model expectations, negedge monitor pops and compares.
module tb_hazard_stall_ctrl;
    localparam int CNT_W = 16;
    localparam int TMO   = 8;
`ifdef HAZARD_PERF_CNT_EN
    localparam int W = 12 + CNT_W + 3*CNT_W;
`else
    localparam int W = 12 + CNT_W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] reg_read_en_ID = '0;
    logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
    logic load_EX = 0, br_EX = 0, jalr_EX = 0, jal_ID = 0, miss_MEM = 0;
    logic bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic flushF, flushD, flushE, flushM, flushW;
    logic stalled, miss_timeout;
    logic [CNT_W-1:0] miss_cycles;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cycles, perf_loaduse, perf_ctrl_flush;
`endif

    hazard_stall_ctrl #(.MISS_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .reg_read_en_ID(reg_read_en_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX),
        .load_EX(load_EX), .br_EX(br_EX), .jalr_EX(jalr_EX), .jal_ID(jal_ID),
        .miss_MEM(miss_MEM),
        .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .stalled(stalled), .miss_cycles(miss_cycles),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_loaduse(perf_loaduse),
        .perf_ctrl_flush(perf_ctrl_flush),
`endif
        .miss_timeout(miss_timeout)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the pipeline is either waiting on memory or not, plus counts.
    bit m_in_miss = 0;
    bit m_tmo     = 0;
    int m_cnt     = 0;
    int m_p_stall = 0, m_p_lu = 0, m_p_ctrl = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    function automatic bit hazard_lu();
        return load_EX && rd_EX != 0 &&
               ((reg_read_en_ID[0] && rs1_ID == rd_EX) || (reg_read_en_ID[1] && rs2_ID == rd_EX));
    endfunction

    function automatic int sat_inc(int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Apply the posedge that just sampled the current inputs.
    task automatic model_update();
        if (!rst) begin
            m_in_miss = 0; m_cnt = 0; m_tmo = 0;
            m_p_stall = 0; m_p_lu = 0; m_p_ctrl = 0;
        end else begin
            if (miss_MEM) m_p_stall = sat_inc(m_p_stall);
            else if (br_EX || jalr_EX || jal_ID) m_p_ctrl = sat_inc(m_p_ctrl);
            else if (hazard_lu()) m_p_lu = sat_inc(m_p_lu);
            if (miss_MEM) begin
                m_cnt     = m_in_miss ? sat_inc(m_cnt) : 1;
                m_in_miss = 1;
                if (m_cnt >= TMO) m_tmo = 1;
            end else begin
                m_in_miss = 0;
            end
        end
    endtask

    // Order in the vector: {F,D,E,M,W} for bubbles and flushes.
    function automatic logic [W-1:0] model_expect();
        logic [4:0] bub = 5'b00000;
        logic [4:0] fl  = 5'b00000;
        logic [CNT_W-1:0] mc = CNT_W'(m_cnt);
        if (!rst)                   fl = 5'b11111;
        else if (miss_MEM)          begin bub = 5'b11110; fl = 5'b00001; end
        else if (br_EX || jalr_EX)  fl = 5'b01100;
        else if (jal_ID)            fl = 5'b01000;
        else if (hazard_lu())       begin bub = 5'b11000; fl = 5'b00100; end
`ifdef HAZARD_PERF_CNT_EN
        return {bub, fl, m_in_miss, mc, m_tmo,
                CNT_W'(m_p_stall), CNT_W'(m_p_lu), CNT_W'(m_p_ctrl)};
`else
        return {bub, fl, m_in_miss, mc, m_tmo};
`endif
    endfunction

    task automatic drive(input logic r, input logic [1:0] rre, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d, input logic ld,
                         input logic b, input logic jr, input logic j, input logic m);
        @(posedge clk);
        #1;
        model_update();
        rst = r; reg_read_en_ID = rre; rs1_ID = s1; rs2_ID = s2; rd_EX = d;
        load_EX = ld; br_EX = b; jalr_EX = jr; jal_ID = j; miss_MEM = m;
        exp_q.push_back(model_expect());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef HAZARD_PERF_CNT_EN
            check("perf_stall_cycles", 64'(perf_stall_cycles), 64'(e[3*CNT_W-1:2*CNT_W]));
            check("perf_loaduse", 64'(perf_loaduse), 64'(e[2*CNT_W-1:CNT_W]));
            check("perf_ctrl_flush", 64'(perf_ctrl_flush), 64'(e[CNT_W-1:0]));
            e = e >> (3*CNT_W);
`endif
            check("bubbles", 64'({bubbleF, bubbleD, bubbleE, bubbleM, bubbleW}), 64'(e[CNT_W+11:CNT_W+7]));
            check("flushes", 64'({flushF, flushD, flushE, flushM, flushW}), 64'(e[CNT_W+6:CNT_W+2]));
            check("stalled", 64'(stalled), 64'(e[CNT_W+1]));
            check("miss_cycles", 64'(miss_cycles), 64'(e[CNT_W:1]));
            check("miss_timeout", 64'(miss_timeout), 64'(e[0]));
        end
    end

    initial begin
        int miss_left = 0;
        // Reset held with miss pending, then released: a fresh miss starts.
        repeat (3) drive(0, 2'b11, 5, 5, 5, 1, 1, 1, 1, 1);
        repeat (3) drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // Load-use on rs1, on rs2, with rd=0, and with disabled read port.
        drive(1, 2'b01, 5, 0, 5, 1, 0, 0, 0, 0);
        drive(1, 2'b10, 0, 7, 7, 1, 0, 0, 0, 0);
        drive(1, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 2'b10, 5, 0, 5, 1, 0, 0, 0, 0);
        // Branch, jalr and jal competing with load-use.
        drive(1, 2'b01, 5, 0, 5, 1, 1, 0, 0, 0);
        drive(1, 2'b01, 5, 0, 5, 1, 0, 1, 0, 0);
        drive(1, 2'b01, 5, 0, 5, 1, 0, 0, 1, 0);
        // 4-cycle miss with branch held, then branch re-evaluated.
        repeat (4) drive(1, 2'b01, 5, 0, 5, 1, 1, 0, 0, 1);
        drive(1, 2'b01, 5, 0, 5, 1, 1, 0, 0, 0);
        idle(3);
        // Long miss crossing the timeout, sticky afterward, cleared by reset.
        repeat (20) drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Counter scenario: 2 load-use, 3 jal, 5-cycle miss.
        repeat (2) drive(1, 2'b01, 3, 0, 3, 1, 0, 0, 0, 0);
        repeat (3) drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (5) drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // Reset mid-miss.
        repeat (3) drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // Randomized traffic with small register numbers to provoke matches.
        for (int i = 0; i < 600; i++) begin
            logic m;
            if (miss_left == 0 && $urandom_range(0, 7) == 0) miss_left = $urandom_range(1, 12);
            m = (miss_left > 0);
            if (miss_left > 0) miss_left--;
            drive($urandom_range(0, 59) != 0, 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, m);
        end
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control unit that drives the bubble/flush inputs of every segment register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves three hazard types: load-use, control transfer, and multi-cycle data-cache miss.
- Holds a RUN/MISS state machine with a saturating miss-cycle counter and a sticky timeout flag.
- Sits beside the datapath in the core top level; it is the producer of the bubbleX/flushX signals that the segment registers consume.

Parameters:
- MISS_TIMEOUT, 1024, miss cycles after which miss_timeout sets (range 1..65535).
- CNT_W, 16, width of the miss-cycle counter and of the performance counters.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-low
- reg_read_en_ID  input  2  [1] rs2 read used, [0] rs1 read used, by the ID instruction
- rs1_ID  input  5  ID source register 1
- rs2_ID  input  5  ID source register 2
- rd_EX  input  5  EX destination register
- load_EX  input  1  EX instruction is a load
- br_EX  input  1  EX branch taken
- jalr_EX  input  1  EX jalr
- jal_ID  input  1  ID jal
- miss_MEM  input  1  data cache miss pending; held high until data is ready
- bubbleF, bubbleD, bubbleE, bubbleM, bubbleW  output  1 each  hold the corresponding segment register
- flushF, flushD, flushE, flushM, flushW  output  1 each  clear the corresponding segment register
- stalled  output  1  state == MISS
- miss_cycles  output  CNT_W  cycles spent in the current or last miss, saturating
- miss_timeout  output  1  sticky; set when miss_cycles reaches MISS_TIMEOUT

Behaviour:
- While rst==0 at a posedge:
  - state<=RUN, miss_cycles<=0, miss_timeout<=0.
  - Outputs are combinational during reset: all flush*=1 and all bubble*=0 while rst==0, independent of the other inputs.
- Output priority, when rst==1:
  1. Miss: miss_MEM==1 or state==MISS with miss_MEM still 1 -> bubbleF/D/E/M=1, flushW=1, all other outputs 0.
  2. Control transfer:
     - br_EX or jalr_EX -> flushD=1, flushE=1.
     - Else jal_ID -> flushD=1.
     - No bubbles in either case.
  3. Load-use:
     - Condition: load_EX and rd_EX!=0 and ((reg_read_en_ID[0] and rs1_ID==rd_EX) or (reg_read_en_ID[1] and rs2_ID==rd_EX)).
     - Response: bubbleF=1, bubbleD=1, flushE=1.
  4. Otherwise all outputs 0.
- Branch and load-use conditions are masked during a miss. They are re-evaluated in the first cycle after miss_MEM falls, because the held segment registers present the same instructions again.
- A simultaneous branch in EX and load-use in ID resolves as branch only. The load-use is discarded because its ID instruction is flushed.
- FSM transitions:
  - RUN -> MISS when miss_MEM==1 at a posedge; miss_cycles<=1.
  - MISS stays while miss_MEM==1; miss_cycles<=miss_cycles+1, saturating at 2^CNT_W-1.
  - MISS -> RUN when miss_MEM==0; miss_cycles keeps its last value until the next miss.
- Stall output latency: the miss stall is asserted combinationally in the same cycle miss_MEM rises, with zero latency. stalled is registered and rises one cycle later.
- miss_timeout sets on the posedge where miss_cycles becomes >= MISS_TIMEOUT. It stays set until reset, and the stall continues.
- Reset mid-miss: state returns to RUN, and flush-all is asserted for the reset cycles. miss_MEM still high after reset starts a fresh miss with miss_cycles=1.
- Back-to-back misses with no gap: miss_MEM stays 1, so this is one continuous MISS and the counter keeps counting.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three extra outputs are added, each CNT_W wide, saturating, and cleared by reset:
  - perf_stall_cycles: cycles with the miss stall active.
  - perf_loaduse: count of load-use bubbles inserted.
  - perf_ctrl_flush: count of cycles in which flushD was caused by br_EX, jalr_EX or jal_ID.
- When undefined, these ports and their registers do not exist and the remaining behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with miss_MEM=1 -> all flush*=1, all bubble*=0, stalled=0, miss_cycles=0. Release rst -> stalled=1 on the next posedge.
- Load-use: load_EX=1, rd_EX=5, rs1_ID=5, reg_read_en_ID=2'b01 -> bubbleF=bubbleD=flushE=1. With rd_EX=0 -> all outputs 0.
- Branch plus load-use in the same cycle: br_EX=1 with the load-use condition true -> flushD=flushE=1, bubbleF=bubbleD=0.
- Miss of 4 cycles: miss_MEM=1 for 4 cycles -> bubbleF/D/E/M=1 and flushW=1 for those 4 cycles, stalled high for 4 cycles delayed by one, miss_cycles=4 afterward. With br_EX=1 during the miss -> flushD stays 0.
- Timeout: MISS_TIMEOUT=8, miss_MEM held 20 cycles -> miss_timeout rises at the posedge where miss_cycles=8 and stays 1 after the miss ends, until reset.
- HAZARD_PERF_CNT_EN defined: 2 load-use events, 3 jal_ID events, a 5-cycle miss -> perf_loaduse=2, perf_ctrl_flush=3, perf_stall_cycles=5.
